// File: rtl/word_pack_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : word_pack_ctrl                                               |
// | Description : Packs 0..2 words per beat into O_WIDTH-bit lines, with a     |
// |               one-word spill across line boundaries and end-of-block flush.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module word_pack_ctrl #(
  parameter int WIDTH   = 32,
  parameter int O_WIDTH = 128
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [1:0]         i_num,
  input  logic [WIDTH-1:0]   i_word1,
  input  logic [WIDTH-1:0]   i_word2,
  input  logic               i_last,
  output logic               o_ready,
  output logic               o_valid,
  output logic [O_WIDTH-1:0] o_word,
  output logic [2:0]         o_count,
  output logic               o_last,
  input  logic               i_ready
);

  localparam int         c_nw       = O_WIDTH / WIDTH;
  localparam logic [3:0] c_nw_tot   = 4'(c_nw);
  localparam logic [2:0] c_nw_cnt   = 3'(c_nw);
  localparam logic [0:0] c_st_fill  = 1'b0;
  localparam logic [0:0] c_st_flush = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [O_WIDTH-1:0] r_fill;
  logic [2:0]         r_cnt;
  logic [WIDTH-1:0]   r_spill;
  logic               r_out_valid;
  logic [O_WIDTH-1:0] r_out_word;
  logic [2:0]         r_out_count;
  logic               r_out_last;

  logic               w_out_free;
  logic               w_accept;
  logic [1:0]         w_n;
  logic [3:0]         w_total;
  logic               w_complete;
  logic               w_overflow;
  logic               w_line_load;
  logic               w_flush_load;
  logic [O_WIDTH-1:0] w_merged;

  assign w_n          = (i_num == 2'd3) ? 2'd2 : i_num;
  assign w_out_free   = ~r_out_valid | i_ready;
  assign w_accept     = i_valid & o_ready;
  assign w_total      = {1'b0, r_cnt} + {2'b00, w_n};
  assign w_complete   = (w_total >= c_nw_tot);
  assign w_overflow   = (w_total > c_nw_tot);
  assign w_line_load  = w_accept & (i_last | w_complete);
  assign w_flush_load = (r_state == c_st_flush) & w_out_free;

  // Unfilled slots of r_fill are always zero, so merging pads lines for free.
  always_comb begin
    w_merged = r_fill;
    for (int k = 0; k < c_nw; k++) begin
      if ((w_n != 2'd0) && ({1'b0, r_cnt} == 4'(k)))
        w_merged[k*WIDTH +: WIDTH] = i_word1;
      if ((w_n == 2'd2) && (({1'b0, r_cnt} + 4'd1) == 4'(k)))
        w_merged[k*WIDTH +: WIDTH] = i_word2;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= c_st_fill;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_fill:  if (w_accept && i_last && w_overflow) w_state_nxt = c_st_flush;
      c_st_flush: if (w_out_free) w_state_nxt = c_st_fill;
      default:    w_state_nxt = c_st_fill;
    endcase
  end

  always_comb begin
    o_ready = (r_state == c_st_fill) & w_out_free;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_fill  <= '0;
      r_cnt   <= 3'd0;
      r_spill <= '0;
    end else if (w_accept) begin
      if (w_line_load) begin
        // A spill from a non-last beat seeds the next line; from a last beat it waits for FLUSH.
        if (w_overflow && !i_last) begin
          r_fill <= {{(O_WIDTH-WIDTH){1'b0}}, i_word2};
          r_cnt  <= 3'd1;
        end else begin
          r_fill <= '0;
          r_cnt  <= 3'd0;
        end
        if (w_overflow && i_last) begin
          r_spill <= i_word2;
        end
      end else begin
        r_fill <= w_merged;
        r_cnt  <= w_total[2:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_out_count <= 3'd0;
      r_out_last  <= 1'b0;
    end else if (w_line_load) begin
      r_out_valid <= 1'b1;
      r_out_word  <= w_merged;
      r_out_count <= w_complete ? c_nw_cnt : w_total[2:0];
      r_out_last  <= i_last & ~w_overflow;
    end else if (w_flush_load) begin
      r_out_valid <= 1'b1;
      r_out_word  <= {{(O_WIDTH-WIDTH){1'b0}}, r_spill};
      r_out_count <= 3'd1;
      r_out_last  <= 1'b1;
    end else if (i_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_valid = r_out_valid;
  assign o_word  = r_out_word;
  assign o_count = r_out_count;
  assign o_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_word_pack_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_word_pack_ctrl                                            |
// | Description : Directed self-checking bench for word_pack_ctrl.             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_word_pack_ctrl;

  logic         i_clk   = 1'b0;
  logic         i_reset = 1'b0;
  logic         i_valid = 1'b0;
  logic [1:0]   i_num   = 2'd0;
  logic [31:0]  i_word1 = '0;
  logic [31:0]  i_word2 = '0;
  logic         i_last  = 1'b0;
  logic         i_ready = 1'b0;
  logic         o_ready;
  logic         o_valid;
  logic [127:0] o_word;
  logic [2:0]   o_count;
  logic         o_last;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  word_pack_ctrl #(.WIDTH(32), .O_WIDTH(128)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_num   (i_num),
    .i_word1 (i_word1),
    .i_word2 (i_word2),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_word  (o_word),
    .o_count (o_count),
    .o_last  (o_last),
    .i_ready (i_ready)
  );

  // Presents one beat for exactly one clock edge; returns 1ns after that edge.
  task automatic send(input logic [31:0] w1, input logic [31:0] w2,
                      input logic [1:0] n, input logic last);
    i_valid = 1'b1; i_word1 = w1; i_word2 = w2; i_num = n; i_last = last;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_last = 1'b0; i_num = 2'd0;
  endtask

  task automatic drain();
    i_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", o_valid); end
    total++; if (o_word !== 128'd0) begin bad++; $display("FAIL rst_word got=%h exp=0", o_word); end
    total++; if (o_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", o_count); end
    total++; if (o_last !== 1'b0) begin bad++; $display("FAIL rst_last got=%0b exp=0", o_last); end
    repeat (2) @(posedge i_clk);
    #1; i_reset = 1'b1; i_ready = 1'b1; #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", o_ready); end
  endtask

  task automatic test_basic();
    drain();
    send(32'h11111111, 32'h22222222, 2'd2, 1'b0);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL basic_early got=%0b exp=0", o_valid); end
    send(32'h33333333, 32'h44444444, 2'd2, 1'b0);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", o_valid); end
    total++; if (o_word !== 128'h44444444_33333333_22222222_11111111) begin
      bad++; $display("FAIL basic_word got=%h exp=44444444333333332222222211111111", o_word); end
    total++; if (o_count !== 3'd4 || o_last !== 1'b0) begin
      bad++; $display("FAIL basic_cnt got=%0d/%0b exp=4/0", o_count, o_last); end
    @(posedge i_clk); #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL basic_onecyc got=%0b exp=0", o_valid); end
    total++; if (o_word !== 128'h44444444_33333333_22222222_11111111) begin
      bad++; $display("FAIL basic_hold got=%h exp=44444444333333332222222211111111", o_word); end
  endtask

  task automatic test_spill();
    drain();
    send(32'hA0A0A0A0, 32'h0, 2'd1, 1'b0);
    send(32'hB0B0B0B0, 32'hC0C0C0C0, 2'd2, 1'b0);
    send(32'hD0D0D0D0, 32'hE0E0E0E0, 2'd2, 1'b0);
    total++; if (o_word !== 128'hD0D0D0D0_C0C0C0C0_B0B0B0B0_A0A0A0A0 || o_count !== 3'd4) begin
      bad++; $display("FAIL spill_line got=%h/%0d exp=D0D0D0D0C0C0C0C0B0B0B0B0A0A0A0A0/4", o_word, o_count); end
    send(32'hF0F0F0F0, 32'h0F0F0F0F, 2'd2, 1'b0);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL spill_nocomplete got=%0b exp=0", o_valid); end
    send(32'h5A5A5A5A, 32'h0, 2'd1, 1'b0);
    total++; if (o_word !== 128'h5A5A5A5A_0F0F0F0F_F0F0F0F0_E0E0E0E0 || o_valid !== 1'b1) begin
      bad++; $display("FAIL spill_carry got=%h/%0b exp=5A5A5A5A0F0F0F0FF0F0F0F0E0E0E0E0/1", o_word, o_valid); end
  endtask

  task automatic test_backpressure();
    drain();
    i_ready = 1'b0;
    send(32'h1, 32'h2, 2'd2, 1'b0);
    send(32'h3, 32'h4, 2'd2, 1'b0);
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%0b exp=0", o_ready); end
    i_valid = 1'b1; i_word1 = 32'h5; i_word2 = 32'h6; i_num = 2'd2; i_last = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    total++; if (o_valid !== 1'b1 || o_word !== 128'h4_00000003_00000002_00000001) begin
      bad++; $display("FAIL bp_hold got=%h/%0b exp=00000004000000030000000200000001/1", o_word, o_valid); end
    i_ready = 1'b1; #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0b exp=1", o_ready); end
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_num = 2'd0;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL bp_taken got=%0b exp=0", o_valid); end
    send(32'h7, 32'h8, 2'd2, 1'b0);
    total++; if (o_valid !== 1'b1 || o_word !== 128'h8_00000007_00000006_00000005) begin
      bad++; $display("FAIL bp_second got=%h/%0b exp=00000008000000070000000600000005/1", o_word, o_valid); end
    @(posedge i_clk); #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL bp_nodup got=%0b exp=0", o_valid); end
  endtask

  task automatic test_last_spill();
    drain();
    send(32'h1, 32'h2, 2'd2, 1'b0);
    send(32'h3, 32'h0, 2'd1, 1'b0);
    send(32'hC0DE0001, 32'hC0DE0002, 2'd2, 1'b1);
    total++; if (o_word !== 128'hC0DE0001_00000003_00000002_00000001 || o_count !== 3'd4 || o_last !== 1'b0) begin
      bad++; $display("FAIL ls_full got=%h/%0d/%0b exp=C0DE0001000000030000000200000001/4/0", o_word, o_count, o_last); end
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL ls_flush_ready got=%0b exp=0", o_ready); end
    @(posedge i_clk); #1;
    total++; if (o_valid !== 1'b1 || o_word !== 128'hC0DE0002 || o_count !== 3'd1 || o_last !== 1'b1) begin
      bad++; $display("FAIL ls_spill got=%h/%0d/%0b/%0b exp=C0DE0002/1/1/1", o_word, o_count, o_last, o_valid); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL ls_ready_back got=%0b exp=1", o_ready); end
    @(posedge i_clk); #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL ls_done got=%0b exp=0", o_valid); end
  endtask

  task automatic test_partial_last();
    drain();
    send(32'h5, 32'h0, 2'd1, 1'b0);
    send(32'h6, 32'h7, 2'd2, 1'b1);
    total++; if (o_word !== 128'h0_00000007_00000006_00000005 || o_count !== 3'd3 || o_last !== 1'b1) begin
      bad++; $display("FAIL pl_partial got=%h/%0d/%0b exp=00000000000000070000000600000005/3/1", o_word, o_count, o_last); end
    send(32'h0, 32'h0, 2'd0, 1'b1);
    total++; if (o_valid !== 1'b1 || o_word !== 128'd0 || o_count !== 3'd0 || o_last !== 1'b1) begin
      bad++; $display("FAIL pl_empty got=%h/%0d/%0b/%0b exp=0/0/1/1", o_word, o_count, o_last, o_valid); end
    send(32'h8, 32'h9, 2'd3, 1'b0);
    send(32'h0, 32'h0, 2'd0, 1'b0);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL pl_num0 got=%0b exp=0", o_valid); end
    send(32'hA, 32'hB, 2'd2, 1'b1);
    total++; if (o_word !== 128'hB_0000000A_00000009_00000008 || o_count !== 3'd4 || o_last !== 1'b1) begin
      bad++; $display("FAIL pl_exact got=%h/%0d/%0b exp=0000000B0000000A0000000900000008/4/1", o_word, o_count, o_last); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL pl_noflush got=%0b exp=1", o_ready); end
  endtask

  task automatic test_back_to_back();
    drain();
    send(32'h21, 32'h22, 2'd2, 1'b1);
    total++; if (o_valid !== 1'b1 || o_word !== 128'h22_00000021 || o_count !== 3'd2) begin
      bad++; $display("FAIL b2b_1 got=%h/%0d exp=0000002200000021/2", o_word, o_count); end
    send(32'h23, 32'h0, 2'd1, 1'b1);
    total++; if (o_valid !== 1'b1 || o_word !== 128'h23 || o_count !== 3'd1) begin
      bad++; $display("FAIL b2b_2 got=%h/%0d/%0b exp=23/1/1", o_word, o_count, o_valid); end
    send(32'h24, 32'h25, 2'd2, 1'b1);
    total++; if (o_valid !== 1'b1 || o_word !== 128'h25_00000024 || o_count !== 3'd2) begin
      bad++; $display("FAIL b2b_3 got=%h/%0d/%0b exp=0000002500000024/2/1", o_word, o_count, o_valid); end
  endtask

  task automatic test_async_reset();
    drain();
    i_ready = 1'b0;
    send(32'h1, 32'h2, 2'd2, 1'b0);
    send(32'h3, 32'h0, 2'd1, 1'b0);
    send(32'hDEAD0001, 32'hDEAD0002, 2'd2, 1'b1);
    total++; if (o_ready !== 1'b0 || o_valid !== 1'b1) begin
      bad++; $display("FAIL ar_flush got=%0b/%0b exp=0/1", o_ready, o_valid); end
    #2; i_reset = 1'b0; #1;
    total++; if (o_valid !== 1'b0 || o_count !== 3'd0 || o_word !== 128'd0) begin
      bad++; $display("FAIL ar_async got=%0b/%0d/%h exp=0/0/0", o_valid, o_count, o_word); end
    @(posedge i_clk); #1;
    i_reset = 1'b1; i_ready = 1'b1; #1;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL ar_ready got=%0b exp=1", o_ready); end
    @(posedge i_clk); #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL ar_nospill got=%0b exp=0", o_valid); end
    send(32'h31, 32'h32, 2'd2, 1'b0);
    send(32'h33, 32'h34, 2'd2, 1'b0);
    total++; if (o_valid !== 1'b1 || o_word !== 128'h34_00000033_00000032_00000031 || o_last !== 1'b0) begin
      bad++; $display("FAIL ar_post got=%h/%0b/%0b exp=00000034000000330000003200000031/1/0", o_word, o_valid, o_last); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_spill();
    test_backpressure();
    test_last_spill();
    test_partial_last();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
